if_fetch_queue: RTL and testbench

- Parametrised successor to the single-cycle fetch stage.
- Decouples the instruction-memory request/response interface from the decode stage.
- Issues sequential fetches with up to DEPTH requests in flight and buffers returned instructions with their PCs in an in-order queue.
- Supports a redirect (branch/jump target) that flushes the queue and discards in-flight responses. Sits between imem and id_stage.

---
 rtl/sys_defs.sv | 11 +
 rtl/fetch_fifo.sv | 47 ++++
 rtl/if_fetch_queue.sv | 101 ++++++++++
 tb/tb_if_fetch_queue.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared fetch-path types and constants used by the fetch queue and its FIFO.
package sys_defs;
  localparam int INST_BYTES   = 4;
  localparam int FETCH_ADDR_W = 64;
  localparam int FETCH_INST_W = 32;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// In-order buffer of fetched {pc, inst} entries; flush wins over push and pop.
module fetch_fifo
  import sys_defs::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  entry_t        din,
  output entry_t        head,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_queue.sv
// Decoupled instruction fetch: credit-limited sequential requests, an in-order
// response queue, and redirect handling that drops responses already in flight.
module if_fetch_queue
  import sys_defs::*;
#(
  parameter int               ADDR_W   = 64,
  parameter int               INST_W   = 32,
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              resp_valid,
  input  logic [INST_W-1:0] resp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst
);

  localparam int                CW      = $clog2(DEPTH + 1);
  localparam int                CW1     = CW + 1;
  localparam logic [CW:0]       DEPTH_C = CW1'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(INST_BYTES);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [ADDR_W-1:0] redirect_base;
  logic [CW-1:0]     count;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     inflight_after_resp;
  logic              accept;
  logic              keep;
  logic              pop;
  entry_t            push_entry;
  entry_t            head;

  assign redirect_base = redirect_pc & ~ADDR_W'(3);

  // Buffered plus outstanding never exceeds DEPTH, so every response has a slot.
  assign req_valid = !redirect_valid && (({1'b0, count} + {1'b0, inflight}) < DEPTH_C);
  assign req_addr  = fetch_pc;
  assign accept    = req_valid && req_ready;

  assign keep                = resp_valid && (drop_cnt == '0) && !redirect_valid;
  assign inflight_after_resp = inflight - CW'(resp_valid);
  assign push_entry          = '{pc: resp_pc, inst: resp_data};

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_pc    = out_valid ? head.pc   : '0;
  assign out_inst  = out_valid ? head.inst : '0;

  // On redirect every response still owed, minus one arriving now, becomes stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_base;
      resp_pc  <= redirect_base;
      inflight <= inflight_after_resp;
      drop_cnt <= inflight_after_resp;
    end else begin
      if (accept) fetch_pc <= fetch_pc + STEP;
      inflight <= inflight_after_resp + CW'(accept);
      if (resp_valid) begin
        if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        else                resp_pc  <= resp_pc + STEP;
      end
    end
  end

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .entry_t(entry_t)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (keep),
    .pop  (pop),
    .flush(redirect_valid),
    .din  (push_entry),
    .head (head),
    .count(count)
  );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: a tagged-epoch imem model and an expected-output queue.
module tb_if_fetch_queue;

  localparam int          ADDR_W   = 64;
  localparam int          INST_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic [INST_W-1:0] resp_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [INST_W-1:0] out_inst;

  typedef struct {
    logic [63:0] addr;
    int          ep;
  } req_t;

  req_t        imem_q[$];
  logic [63:0] model_q[$];
  int          epoch;
  logic [63:0] exp_req_pc;
  int          tests  = 0;
  int          failed = 0;

  logic        s_req_valid;
  logic [63:0] s_req_addr;
  logic        s_out_valid;
  logic [63:0] s_out_pc;

  if_fetch_queue #(
    .ADDR_W  (ADDR_W),
    .INST_W  (INST_W),
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst      (out_inst)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    req_ready = 1'b0;
    resp_valid = 1'b0;
    resp_data = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    imem_q.delete();
    model_q.delete();
    epoch = 0;
    exp_req_pc = RESET_PC;
  endtask

  // One clock of stimulus; mode 0 = imem answers whenever owed, 1 = random, 2 = never.
  task automatic run_cycle(input bit rdr, input logic [63:0] rpc, input bit ordy,
                           input bit rrdy, input int mode);
    bit          exp_rv;
    bit          do_resp;
    bit          exp_ov;
    req_t        r;
    logic [63:0] exp_pc;
    logic [31:0] exp_inst;
    redirect_valid = rdr;
    redirect_pc    = rpc;
    out_ready      = ordy;
    req_ready      = rrdy;
    do_resp = (imem_q.size() != 0) &&
              (mode == 0 || (mode == 1 && $urandom_range(0, 1) == 1));
    resp_valid = do_resp;
    resp_data  = do_resp ? inst_of(imem_q[0].addr) : $urandom;
    #1;
    exp_rv   = !rdr && (model_q.size() + imem_q.size() < DEPTH);
    exp_ov   = (model_q.size() != 0);
    exp_pc   = exp_ov ? model_q[0] : 64'h0;
    exp_inst = exp_ov ? inst_of(model_q[0]) : 32'h0;
    s_req_valid = req_valid;
    s_req_addr  = req_addr;
    s_out_valid = out_valid;
    s_out_pc    = out_pc;
    tests++;
    if (req_valid !== exp_rv) begin
      failed++;
      $display("[TB] FAIL req_valid: got %b expected %b", req_valid, exp_rv);
    end
    tests++;
    if (req_addr !== exp_req_pc) begin
      failed++;
      $display("[TB] FAIL req_addr: got %h expected %h", req_addr, exp_req_pc);
    end
    tests++;
    if (out_valid !== exp_ov) begin
      failed++;
      $display("[TB] FAIL out_valid: got %b expected %b", out_valid, exp_ov);
    end
    tests++;
    if (out_pc !== exp_pc) begin
      failed++;
      $display("[TB] FAIL out_pc: got %h expected %h", out_pc, exp_pc);
    end
    tests++;
    if (out_inst !== exp_inst) begin
      failed++;
      $display("[TB] FAIL out_inst: got %h expected %h", out_inst, exp_inst);
    end
    tests++;
    if (dut.inflight !== 3'(imem_q.size())) begin
      failed++;
      $display("[TB] FAIL inflight: got %0d expected %0d", dut.inflight, imem_q.size());
    end
    tests++;
    if (int'(dut.count) + int'(dut.inflight) > DEPTH || dut.drop_cnt > dut.inflight) begin
      failed++;
      $display("[TB] FAIL credit_invariant: got count=%0d inflight=%0d drop=%0d expected sum<=%0d drop<=inflight",
               dut.count, dut.inflight, dut.drop_cnt, DEPTH);
    end
    @(posedge clk);
    #1;
    if (ordy && model_q.size() != 0) void'(model_q.pop_front());
    if (do_resp) begin
      r = imem_q.pop_front();
      if (!rdr && r.ep == epoch) model_q.push_back(r.addr);
    end
    if (exp_rv && rrdy) begin
      imem_q.push_back('{addr: exp_req_pc, ep: epoch});
      exp_req_pc += 64'd4;
    end
    if (rdr) begin
      epoch++;
      model_q.delete();
      exp_req_pc = {rpc[63:2], 2'b00};
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    req_ready = 1'b0;
    resp_valid = 1'b0;
    resp_data = '0;
    out_ready = 1'b0;
    #2;
    tests++;
    if (req_valid !== 1'b1) begin
      failed++;
      $display("[TB] FAIL reset_req_valid: got %b expected 1", req_valid);
    end
    tests++;
    if (req_addr !== RESET_PC) begin
      failed++;
      $display("[TB] FAIL reset_req_addr: got %h expected %h", req_addr, RESET_PC);
    end
    tests++;
    if (out_valid !== 1'b0 || out_pc !== 64'h0 || out_inst !== 32'h0) begin
      failed++;
      $display("[TB] FAIL reset_outputs: got %b/%h/%h expected 0/0/0", out_valid, out_pc, out_inst);
    end
    do_reset();
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      run_cycle(1'b0, 64'h0, 1'b1, 1'b1, 0);
      if (i < 3) begin
        tests++;
        if (s_req_addr !== 64'(i * 4)) begin
          failed++;
          $display("[TB] FAIL stream_addr: got %h expected %h", s_req_addr, 64'(i * 4));
        end
      end
      if (i >= 2) begin
        tests++;
        if (s_out_valid !== 1'b1) begin
          failed++;
          $display("[TB] FAIL stream_valid: got %b expected 1", s_out_valid);
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (8) run_cycle(1'b0, 64'h0, 1'b0, 1'b1, 0);
    tests++;
    if (dut.count !== 3'd4 || s_req_valid !== 1'b0) begin
      failed++;
      $display("[TB] FAIL stall_full: got count=%0d req_valid=%b expected 4/0", dut.count, s_req_valid);
    end
    run_cycle(1'b0, 64'h0, 1'b1, 1'b1, 0);
    run_cycle(1'b0, 64'h0, 1'b1, 1'b1, 0);
    tests++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 64'h10) begin
      failed++;
      $display("[TB] FAIL stall_resume: got %b/%h expected 1/0000000000000010", s_req_valid, s_req_addr);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_pc;
    exp_pc = 64'h8;
    for (int i = 0; i < 8; i++) begin
      run_cycle(1'b0, 64'h0, 1'b1, 1'b1, 0);
      tests++;
      if (s_out_valid !== 1'b1 || s_out_pc !== exp_pc) begin
        failed++;
        $display("[TB] FAIL b2b_order: got %b/%h expected 1/%h", s_out_valid, s_out_pc, exp_pc);
      end
      exp_pc += 64'd4;
    end
  endtask

  task automatic test_redirect();
    bit found;
    do_reset();
    run_cycle(1'b1, 64'h20, 1'b1, 1'b1, 2);
    repeat (3) run_cycle(1'b0, 64'h0, 1'b1, 1'b1, 2);
    tests++;
    if (dut.inflight !== 3'd3) begin
      failed++;
      $display("[TB] FAIL redir_inflight: got %0d expected 3", dut.inflight);
    end
    run_cycle(1'b1, 64'h103, 1'b1, 1'b1, 2);
    tests++;
    if (dut.drop_cnt !== 3'd3) begin
      failed++;
      $display("[TB] FAIL redir_drop: got %0d expected 3", dut.drop_cnt);
    end
    run_cycle(1'b0, 64'h0, 1'b1, 1'b1, 0);
    tests++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 64'h100) begin
      failed++;
      $display("[TB] FAIL redir_addr: got %b/%h expected 1/0000000000000100", s_req_valid, s_req_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      run_cycle(1'b0, 64'h0, 1'b1, 1'b1, 0);
      found = s_out_valid;
    end
    tests++;
    if (!found || s_out_pc !== 64'h100) begin
      failed++;
      $display("[TB] FAIL redir_first_out: got %b/%h expected 1/0000000000000100", found, s_out_pc);
    end
  endtask

  task automatic test_redirect_with_resp();
    do_reset();
    run_cycle(1'b1, 64'h200, 1'b0, 1'b1, 2);
    repeat (2) run_cycle(1'b0, 64'h0, 1'b0, 1'b1, 2);
    run_cycle(1'b1, 64'h300, 1'b0, 1'b1, 0);
    tests++;
    if (dut.drop_cnt !== 3'd1 || dut.inflight !== 3'd1) begin
      failed++;
      $display("[TB] FAIL redir_resp_drop: got drop=%0d inflight=%0d expected 1/1", dut.drop_cnt, dut.inflight);
    end
    run_cycle(1'b0, 64'h0, 1'b0, 1'b1, 0);
    tests++;
    if (dut.drop_cnt !== 3'd0 || dut.count !== 3'd0) begin
      failed++;
      $display("[TB] FAIL redir_resp_discard: got drop=%0d count=%0d expected 0/0", dut.drop_cnt, dut.count);
    end
    run_cycle(1'b0, 64'h0, 1'b0, 1'b1, 0);
    tests++;
    if (out_valid !== 1'b1 || out_pc !== 64'h300 || out_inst !== inst_of(64'h300)) begin
      failed++;
      $display("[TB] FAIL redir_resp_keep: got %b/%h/%h expected 1/0000000000000300/%h",
               out_valid, out_pc, out_inst, inst_of(64'h300));
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 10 && model_q.size() < 2; i++)
      run_cycle(1'b0, 64'h0, 1'b0, 1'b1, 0);
    #2;
    rst = 1'b1;
    redirect_valid = 1'b0;
    req_ready = 1'b0;
    resp_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_pc !== 64'h0 || dut.count !== 3'd0) begin
      failed++;
      $display("[TB] FAIL async_reset_out: got %b/%h/%0d expected 0/0/0", out_valid, out_pc, dut.count);
    end
    tests++;
    if (req_valid !== 1'b1 || req_addr !== RESET_PC) begin
      failed++;
      $display("[TB] FAIL async_reset_req: got %b/%h expected 1/%h", req_valid, req_addr, RESET_PC);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    imem_q.delete();
    model_q.delete();
    epoch = 0;
    exp_req_pc = RESET_PC;
    run_cycle(1'b0, 64'h0, 1'b1, 1'b1, 0);
    tests++;
    if (s_req_addr !== RESET_PC) begin
      failed++;
      $display("[TB] FAIL async_reset_restart: got %h expected %h", s_req_addr, RESET_PC);
    end
    repeat (6) run_cycle(1'b0, 64'h0, 1'b1, 1'b1, 0);
  endtask

  task automatic test_random();
    bit          rdr;
    logic [63:0] rpc;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rdr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0)
        rpc = {60'hFFF_FFFF_FFFF_FFFF, 4'($urandom_range(0, 15))};
      else
        rpc = {$urandom, $urandom};
      run_cycle(rdr, rpc, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1);
    end
    repeat (20) run_cycle(1'b0, 64'h0, 1'b1, 1'b0, 0);
    tests++;
    if (out_valid !== 1'b0 || dut.inflight !== 3'd0) begin
      failed++;
      $display("[TB] FAIL random_drain: got %b/%0d expected 0/0", out_valid, dut.inflight);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_back_to_back();
    test_redirect();
    test_redirect_with_resp();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
